// File: rtl/noc_packet_receiver.sv
// Local-port NoC receive stage: framing/destination checks, FWFT payload FIFO and a
// registered per-packet descriptor. Statistics counters are built only with NOC_RX_STATS_EN.
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif
`ifndef Noc_ID_X_Width
`define Noc_ID_X_Width 4
`endif
`ifndef Noc_ID_Y_Width
`define Noc_ID_Y_Width 4
`endif
`ifndef Noc_Point_H
`define Noc_Point_H 28
`endif
`ifndef Noc_Source_Point
`define Noc_Source_Point 20
`endif
`ifndef Axi_Len_Point
`define Axi_Len_Point 8
`endif
`ifndef Noc_Point_E
`define Noc_Point_E 4
`endif
`ifndef Noc_Head_H
`define Noc_Head_H 4'hA
`endif
`ifndef Noc_Head_E
`define Noc_Head_E 4'h5
`endif
`ifndef Noc_Tail_H
`define Noc_Tail_H 4'hC
`endif
`ifndef Noc_Tail_E
`define Noc_Tail_E 4'h3
`endif

module noc_packet_receiver #(
   parameter logic [`Noc_ID_X_Width-1:0] X_ID           = '0,
   parameter logic [`Noc_ID_Y_Width-1:0] Y_ID           = '0,
   parameter int                         FIFO_DEPTH     = 4,
   parameter int                         MAX_DATA_FLITS = 16,
   localparam int                        LW             = $clog2(MAX_DATA_FLITS + 1)
) (
   input  logic                       noc_clk,
   input  logic                       noc_rst,
   input  logic                       receive_valid,
   output logic                       receive_ready,
   input  logic [`Noc_Data_Width-1:0] receive_flit,
   input  logic                       receive_is_header,
   input  logic                       receive_is_tail,
   output logic                       data_valid,
   input  logic                       data_ready,
   output logic [`Noc_Data_Width-1:0] data_flit,
   output logic                       desc_valid,
   input  logic                       desc_ready,
   output logic [`Noc_ID_X_Width-1:0] desc_src_x,
   output logic [`Noc_ID_Y_Width-1:0] desc_src_y,
   output logic [LW-1:0]              desc_len,
   output logic [3:0]                 desc_err,
   output logic [15:0]                rx_pkt_cnt,
   output logic [15:0]                rx_err_cnt
);

   localparam int DW  = `Noc_Data_Width;
   localparam int XW  = `Noc_ID_X_Width;
   localparam int YW  = `Noc_ID_Y_Width;
   localparam int IDW = XW + YW;
   localparam int PW  = $clog2(FIFO_DEPTH);
   localparam int CW  = PW + 1;
   localparam logic [IDW-1:0] LOCAL_ID = {X_ID, Y_ID};

   typedef enum logic [1:0] {IDLE, BODY, DROP} state_t;

   state_t            state_q, state_d;
   logic [IDW-1:0]    src_q, src_d;
   logic [3:0]        perr_q, perr_d;
   logic [LW-1:0]     cnt_q, cnt_d;
   logic              desc_valid_q, desc_valid_d;
   logic [IDW-1:0]    dsrc_q, dsrc_d;
   logic [LW-1:0]     dlen_q, dlen_d;
   logic [3:0]        derr_q, derr_d;

   logic [DW-1:0]     mem_q [FIFO_DEPTH];
   logic [PW-1:0]     wr_q, rd_q;
   logic [CW-1:0]     fcnt_q;
   logic              push, pop, accept;

   logic [DW-`Noc_Point_H-1:0]               f_h;
   logic [`Axi_Len_Point-`Noc_Point_E-1:0]   f_e;
   logic [IDW-1:0]    f_src, f_dst;
   logic [1:0]        hdr_err;
   logic              tail_bad;

   assign f_h      = receive_flit[DW-1:`Noc_Point_H];
   assign f_e      = receive_flit[`Axi_Len_Point-1:`Noc_Point_E];
   assign f_src    = receive_flit[`Noc_Point_H-1:`Noc_Source_Point];
   assign f_dst    = receive_flit[`Noc_Source_Point-1 -: IDW];
   assign hdr_err  = {f_dst != LOCAL_ID, (f_h != `Noc_Head_H) || (f_e != `Noc_Head_E)};
   assign tail_bad = (f_h != `Noc_Tail_H) || (f_e != `Noc_Tail_E) || (f_src != src_q);

   assign receive_ready = !noc_rst && (fcnt_q < CW'(FIFO_DEPTH)) && !desc_valid_q;
   assign accept        = receive_valid && receive_ready;
   assign data_valid    = (fcnt_q != '0);
   assign data_flit     = data_valid ? mem_q[rd_q] : '0;
   assign pop           = data_ready && data_valid;

   assign desc_valid = desc_valid_q;
   assign desc_src_x = dsrc_q[IDW-1:YW];
   assign desc_src_y = dsrc_q[YW-1:0];
   assign desc_len   = dlen_q;
   assign desc_err   = derr_q;

   always_comb begin
      state_d      = state_q;
      src_d        = src_q;
      perr_d       = perr_q;
      cnt_d        = cnt_q;
      desc_valid_d = desc_valid_q;
      dsrc_d       = dsrc_q;
      dlen_d       = dlen_q;
      derr_d       = derr_q;
      push         = 1'b0;
      if (desc_valid_q && desc_ready) desc_valid_d = 1'b0;
      if (accept) begin
         if (state_q != IDLE && (receive_is_header || receive_is_tail)) begin
            desc_valid_d = 1'b1;
            dsrc_d       = src_q;
            dlen_d       = cnt_q;
            derr_d       = perr_q | (((receive_is_header || tail_bad)) ? 4'b1000 : 4'b0000);
            state_d      = IDLE;
         end
         // A header+tail arriving mid-packet has no descriptor slot left; it is dropped as stray.
         if (receive_is_header && !(state_q != IDLE && receive_is_tail)) begin
            src_d  = f_src;
            perr_d = {2'b00, hdr_err};
            cnt_d  = '0;
            if (receive_is_tail) begin
               desc_valid_d = 1'b1;
               dsrc_d       = f_src;
               dlen_d       = '0;
               derr_d       = {2'b00, hdr_err};
               state_d      = IDLE;
            end else begin
               state_d = (hdr_err != 2'b00) ? DROP : BODY;
            end
         end else if (!receive_is_header && !receive_is_tail && state_q == BODY) begin
            if (cnt_q < LW'(MAX_DATA_FLITS)) begin
               push  = 1'b1;
               cnt_d = cnt_q + LW'(1);
            end else begin
               perr_d  = perr_q | 4'b0100;
               state_d = DROP;
            end
         end
      end
   end

   always_ff @(posedge noc_clk or posedge noc_rst) begin
      if (noc_rst) begin
         state_q      <= IDLE;
         src_q        <= '0;
         perr_q       <= '0;
         cnt_q        <= '0;
         desc_valid_q <= 1'b0;
         dsrc_q       <= '0;
         dlen_q       <= '0;
         derr_q       <= '0;
         wr_q         <= '0;
         rd_q         <= '0;
         fcnt_q       <= '0;
      end else begin
         state_q      <= state_d;
         src_q        <= src_d;
         perr_q       <= perr_d;
         cnt_q        <= cnt_d;
         desc_valid_q <= desc_valid_d;
         dsrc_q       <= dsrc_d;
         dlen_q       <= dlen_d;
         derr_q       <= derr_d;
         if (push) wr_q <= wr_q + PW'(1);
         if (pop)  rd_q <= rd_q + PW'(1);
         case ({push, pop})
            2'b10:   fcnt_q <= fcnt_q + CW'(1);
            2'b01:   fcnt_q <= fcnt_q - CW'(1);
            default: fcnt_q <= fcnt_q;
         endcase
      end
   end

   // Storage is not reset; data_flit is gated by data_valid instead.
   always_ff @(posedge noc_clk) begin
      if (push) mem_q[wr_q] <= receive_flit;
   end

`ifdef NOC_RX_STATS_EN
   logic [15:0] pkt_cnt_q, err_cnt_q;
   logic        pkt_load, stray;
   logic [1:0]  err_inc;

   function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {15'b0, b};
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

   assign pkt_load = desc_valid_d && !desc_valid_q;
   assign stray    = accept && ((state_q == IDLE && !receive_is_header) ||
                                (state_q != IDLE && receive_is_header && receive_is_tail));
   assign err_inc  = {1'b0, stray} + {1'b0, pkt_load && (derr_d != 4'b0000)};

   always_ff @(posedge noc_clk or posedge noc_rst) begin
      if (noc_rst) begin
         pkt_cnt_q <= '0;
         err_cnt_q <= '0;
      end else begin
         pkt_cnt_q <= sat_add(pkt_cnt_q, {1'b0, pkt_load});
         err_cnt_q <= sat_add(err_cnt_q, err_inc);
      end
   end

   assign rx_pkt_cnt = pkt_cnt_q;
   assign rx_err_cnt = err_cnt_q;
`else
   assign rx_pkt_cnt = '0;
   assign rx_err_cnt = '0;
`endif

endmodule

// File: doc/noc_packet_receiver.md
# noc_packet_receiver

Local-port receive stage that sits directly downstream of a router's local output port, in place of a test node's ad-hoc receive FSM. It consumes header/data/tail flits, checks framing markers and destination, and buffers payload flits in a small FIFO. On each tail it emits one packet descriptor carrying source coordinates, payload length and error bits.

## Interface
Parameters:
- X_ID, 0, this node's X coordinate (`Noc_ID_X_Width bits)
- Y_ID, 0, this node's Y coordinate (`Noc_ID_Y_Width bits)
- FIFO_DEPTH, 4, payload FIFO entries (power of two, ≥2)
- MAX_DATA_FLITS, 16, maximum data flits per packet; LW = $clog2(MAX_DATA_FLITS+1)

Ports:
- noc_clk  in  1  clock. One clock only.
- noc_rst  in  1  reset, asynchronous assert, active-high.
- receive_valid  in  1  flit valid from router
- receive_ready  out  1  flit accepted when valid&&ready
- receive_flit  in  `Noc_Data_Width  flit
- receive_is_header  in  1  header flag
- receive_is_tail  in  1  tail flag
- data_valid  out  1  payload FIFO non-empty
- data_ready  in  1  consumer pop
- data_flit  out  `Noc_Data_Width  FIFO head, first-word-fall-through
- desc_valid  out  1  descriptor pending
- desc_ready  in  1  descriptor consumed when valid&&ready
- desc_src_x  out  `Noc_ID_X_Width  source X from header
- desc_src_y  out  `Noc_ID_Y_Width  source Y from header
- desc_len  out  LW  payload flits pushed for this packet
- desc_err  out  4  [0] header marker, [1] dest mismatch, [2] overflow, [3] tail/framing
- rx_pkt_cnt  out  16  descriptors emitted (stats)
- rx_err_cnt  out  16  descriptors with desc_err≠0 plus stray flits (stats)

## Operation
- Field decode: H marker = flit[`Noc_Data_Width-1:`Noc_Point_H]; E marker = flit[`Axi_Len_Point-1:`Noc_Point_E]; source ID = flit[`Noc_Point_H-1:`Noc_Source_Point] (X high, Y low); dest ID = the next X+Y bits immediately below source.
- States: IDLE, BODY, DROP.
- IDLE, header accepted: latch source; err[0] set if H≠`Noc_Head_H or E≠`Noc_Head_E; err[1] set if dest≠{X_ID,Y_ID}. Any error → DROP, else BODY. Count cleared to 0.
- IDLE, non-header accepted: discarded as a stray flit; no descriptor; rx_err_cnt increments.
- BODY, data flit (neither flag): pushed if count<MAX_DATA_FLITS, count++. Otherwise err[2] set, flit dropped, → DROP.
- BODY/DROP, tail: err[3] set if H≠`Noc_Tail_H, E≠`Noc_Tail_E, or tail source≠latched source. Descriptor loaded → IDLE.
- DROP: data flits are accepted and discarded.
- BODY/DROP, header flit: the current packet is closed with err[3] set and its descriptor is loaded. The new header is processed in the same cycle as if in IDLE.
- Flit with header and tail both set, in IDLE: zero-length packet. Header checks only; descriptor with len=0 → IDLE.
- Consumer uses desc_len to frame payload, and discards the payload when desc_err≠0.

## Timing
- receive_ready = !noc_rst && fifo_count<FIFO_DEPTH && !desc_valid. Combinational from registered state; independent of receive_valid.
- A pushed flit appears on data_flit/data_valid the cycle after acceptance.
- The descriptor is registered: desc_valid rises the cycle after the closing flit is accepted. It holds stable until desc_ready.
- Push and pop in the same cycle leave fifo_count unchanged. Read and write pointers wrap modulo FIFO_DEPTH.
- FIFO full: ready low and no push. Popping when empty has no effect.
- Reset values:
  - all valids 0; receive_ready 0 while noc_rst is high
  - data_flit 0
  - all desc_* fields 0
  - counters 0; FSM in IDLE; FIFO empty
- Reset mid-packet discards the partial packet and buffered payload without emitting a descriptor.

## Configuration
- NOC_RX_STATS_EN defined:
  - rx_pkt_cnt increments on every descriptor load.
  - rx_err_cnt increments on every descriptor load with nonzero err, and on every stray flit.
  - Both counters saturate at 16'hFFFF.
- NOC_RX_STATS_EN undefined: both ports are tied to 0 and no counter logic is built.

## Test plan
- Header (src 1,0 → dest X_ID,Y_ID), 1 data 0xFFFF…, tail, all with valid markers → data_flit=0xFFFF… one cycle later; desc src=(1,0), len=1, err=0; rx_pkt_cnt=1.
- Header with dest≠local plus 3 data + tail → FIFO stays empty; desc len=0, err=4'b0010; rx_err_cnt=1.
- MAX_DATA_FLITS+2 data flits, data_ready=1 → 16 pushed; desc len=16, err=4'b0100.
- data_ready=0, 6 data flits, FIFO_DEPTH=4 → receive_ready drops after 4th push. Raising data_ready resumes flow with no flit lost or duplicated.
- Header, 2 data, second header → first desc len=2, err=4'b1000. The second packet proceeds normally after desc_ready.
- noc_rst pulsed after header+1 data → no descriptor, data_valid=0, FSM IDLE. The next clean packet is received with err=0.
